// File: rtl/cnn_frame_driver.sv
// cnn_frame_driver: host-side frame buffer and pixel streamer for the CNN core.
// Holds one 28x28 8-bit image, pulses the core through reset, streams every
// pixel on consecutive cycles, and collects the core's first decision (or
// reports a timeout when no decision arrives).
module cnn_frame_driver #(
  parameter int IMG_PIXELS   = 784,
  parameter int ADDR_BITS    = 10,
  parameter int RST_CYCLES   = 2,
  parameter int TIMEOUT      = 4096,
  parameter int TIMEOUT_BITS = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           result,
  output logic                 timeout_err,
  output logic                 core_rst_n,
  output logic [7:0]           core_data,
  input  logic                 core_valid,
  input  logic [3:0]           core_decision
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_STREAM,
    S_WAIT,
    S_FIN
  } state_t;

  // Sized constants so every comparison below is width-matched.
  localparam logic [ADDR_BITS:0]      PIX_LIMIT = (ADDR_BITS+1)'(IMG_PIXELS);
  localparam logic [ADDR_BITS-1:0]    LAST_PIX  = ADDR_BITS'(IMG_PIXELS - 1);
  localparam logic [TIMEOUT_BITS-1:0] RST_LAST  = TIMEOUT_BITS'(RST_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST  = TIMEOUT_BITS'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    pix_q, pix_d;          // index of the pixel now on core_data
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;          // shared CRST / WAIT cycle counter
  logic                    got_q, got_d;          // a decision was already captured this frame
  logic [3:0]              dec_q, dec_d;          // decision captured while streaming
  logic [3:0]              result_q, result_d;
  logic                    terr_q, terr_d;
  logic                    core_rst_n_q, core_rst_n_d;
  logic [7:0]              core_data_q;

  logic                    rd_en;
  logic [ADDR_BITS-1:0]    rd_addr;
  logic                    wr_ok;

  logic [7:0]              mem [IMG_PIXELS];

  // Host writes land only while idle and only inside the frame.
  assign wr_ok = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < PIX_LIMIT);

  // Buffer write port.
  // NOTE: the pixel array has no reset on purpose; clearing it would defeat
  // RAM inference and the image must survive a mid-frame reset anyway.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered buffer read; doubles as the core_data output register so the
  // core sees zero whenever no pixel is being streamed.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_data_q <= '0;
    end else if (rd_en) begin
      core_data_q <= mem[rd_addr];
    end else begin
      core_data_q <= '0;
    end
  end

  // Next-state, counters, read request and decision capture.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    pix_d    = pix_q;
    cnt_d    = cnt_q;
    got_d    = got_q;
    dec_d    = dec_q;
    result_d = result_q;
    terr_d   = terr_q;
    rd_en    = 1'b0;
    rd_addr  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CRST;
          terr_d  = 1'b0;
          cnt_d   = '0;
          got_d   = 1'b0;
          pix_d   = '0;
        end
      end

      S_CRST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) begin
          // Issue the read of pixel 0 now so it is on core_data in the first
          // streaming cycle.
          rd_en   = 1'b1;
          rd_addr = '0;
          pix_d   = '0;
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (core_valid && !got_q) begin
          got_d = 1'b1;
          dec_d = core_decision;
        end
        if (pix_q != LAST_PIX) begin
          // Prefetch the next pixel; the counter stops at the last pixel.
          rd_en   = 1'b1;
          rd_addr = pix_q + 1'b1;
          pix_d   = pix_q + 1'b1;
        end else if (got_d) begin
          result_d = dec_d;
          state_d  = S_FIN;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (core_valid) begin
          result_d = core_decision;
          state_d  = S_FIN;
        end else if (cnt_q == TMO_LAST) begin
          result_d = 4'hF;
          terr_d   = 1'b1;
          state_d  = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Core leaves reset exactly when streaming begins and re-enters it in IDLE.
    core_rst_n_d = (state_d == S_STREAM) || (state_d == S_WAIT) || (state_d == S_FIN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      cnt_q        <= '0;
      got_q        <= 1'b0;
      dec_q        <= '0;
      result_q     <= '0;
      terr_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      cnt_q        <= cnt_d;
      got_q        <= got_d;
      dec_q        <= dec_d;
      result_q     <= result_d;
      terr_q       <= terr_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign busy        = (state_q == S_CRST) || (state_q == S_STREAM) || (state_q == S_WAIT);
  assign done        = (state_q == S_FIN);
  assign result      = result_q;
  assign timeout_err = terr_q;
  assign core_rst_n  = core_rst_n_q;
  assign core_data   = core_data_q;

endmodule

// File: tb/tb_cnn_frame_driver.sv
// tb_cnn_frame_driver: scoreboard bench for cnn_frame_driver. Expected pixels
// and expected decisions are queued when a frame is started and popped as the
// DUT streams pixels and signals done.
module tb_cnn_frame_driver;

  localparam int IMG_PIXELS = 784;
  localparam int ADDR_BITS  = 10;
  localparam int RST_CYC    = 2;
  localparam int TIMEOUT    = 4096;

  typedef struct packed {
    logic [3:0] res;
    logic       terr;
  } res_t;

  logic                 clk;
  logic                 rst;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [3:0]           result;
  logic                 timeout_err;
  logic                 core_rst_n;
  logic [7:0]           core_data;
  logic                 core_valid;
  logic [3:0]           core_decision;

  logic [7:0] img [IMG_PIXELS];   // bench copy of the frame buffer
  logic [7:0] exp_pix_q [$];
  res_t       exp_res_q [$];
  int         total;
  int         bad;

  cnn_frame_driver #(
    .IMG_PIXELS  (IMG_PIXELS),
    .ADDR_BITS   (ADDR_BITS),
    .RST_CYCLES  (RST_CYC),
    .TIMEOUT     (TIMEOUT),
    .TIMEOUT_BITS(13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .timeout_err  (timeout_err),
    .core_rst_n   (core_rst_n),
    .core_data    (core_data),
    .core_valid   (core_valid),
    .core_decision(core_decision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // All sampling and driving happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Queue the expected stream/result, assert start and walk the core-reset window.
  task automatic start_frame(input logic [3:0] exp_res, input logic exp_terr);
    res_t e;
    for (int i = 0; i < IMG_PIXELS; i++) exp_pix_q.push_back(img[i]);
    e.res  = exp_res;
    e.terr = exp_terr;
    exp_res_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("terr_cleared", timeout_err, 0);
    check("done_low_start", done, 0);
    for (int k = 0; k < RST_CYC; k++) begin
      check("crst_low", core_rst_n, 0);
      tick();
    end
  endtask

  // Compare n_pix streamed pixels; optionally inject core_valid pulses and a
  // start/write poke on chosen pixel indices.
  task automatic stream(input int n_pix, input int v1_idx, input logic [3:0] d1,
                        input int v2_idx, input logic [3:0] d2, input int poke_idx);
    for (int i = 0; i < n_pix; i++) begin
      check("pixel", core_data, exp_pix_q.pop_front());
      check("stream_rst_n", core_rst_n, 1);
      core_valid    = (i == v1_idx) || (i == v2_idx);
      core_decision = (i == v1_idx) ? d1 : ((i == v2_idx) ? d2 : 4'hE);
      if (i == poke_idx) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 10'd5;
        wr_data = 8'hAA;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      tick();
    end
    core_valid    = 1'b0;
    core_decision = 4'h0;
    start         = 1'b0;
    wr_en         = 1'b0;
  endtask

  // Wait for done (bounded), drive a decision at cycle v1_k after the stream
  // ended, and check the latency and the scoreboarded result.
  task automatic await_done(input int v1_k, input logic [3:0] d1, input int exp_k, input logic hold);
    int   k;
    res_t e;
    k = 0;
    check("post_stream_data", core_data, 0);
    start = hold;
    while (done !== 1'b1 && k < TIMEOUT + 8) begin
      core_valid    = (k == v1_k);
      core_decision = (k == v1_k) ? d1 : 4'hE;
      tick();
      k++;
    end
    core_valid    = 1'b0;
    core_decision = 4'h0;
    e = exp_res_q.pop_front();
    check("done_latency", k, exp_k);
    check("result", result, e.res);
    check("timeout_err", timeout_err, e.terr);
    check("busy_at_done", busy, 0);
    tick();
    check("done_one_pulse", done, 0);
    check("idle_core_rst_n", core_rst_n, 0);
    check("result_hold", result, e.res);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    start         = 1'b0;
    core_valid    = 1'b0;
    core_decision = 4'h0;

    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_data", core_data, 0);
    rst = 1'b0;
    tick();

    // Ramp image: pixel[i] = i mod 256.
    for (int i = 0; i < IMG_PIXELS; i++) begin
      img[i]  = i[7:0];
      wr_en   = 1'b1;
      wr_addr = ADDR_BITS'(i);
      wr_data = i[7:0];
      tick();
    end
    wr_en = 1'b0;
    check("idle_core_data", core_data, 0);

    // Frame A: decision 7 arrives 300 cycles into WAIT.
    start_frame(4'h7, 1'b0);
    stream(IMG_PIXELS, -1, 4'h0, -1, 4'h0, -1);
    await_done(300, 4'h7, 301, 1'b0);

    // Frame B: no decision, timeout after TIMEOUT WAIT cycles.
    start_frame(4'hF, 1'b1);
    stream(IMG_PIXELS, -1, 4'h0, -1, 4'h0, -1);
    await_done(-1, 4'h0, TIMEOUT, 1'b0);
    tick();
    tick();
    check("terr_holds", timeout_err, 1);
    check("result_f_holds", result, 4'hF);

    // Frame C: start + buffer write while streaming are ignored; two decisions
    // during the stream, only the first counts, finish without a WAIT phase.
    start_frame(4'h3, 1'b0);
    stream(IMG_PIXELS, 200, 4'h3, 500, 4'h9, 100);
    await_done(-1, 4'h0, 0, 1'b0);
    tick();
    check("no_restart_busy", busy, 0);
    check("no_second_done", done, 0);

    // Idle write that must stick.
    wr_en   = 1'b1;
    wr_addr = 10'd10;
    wr_data = 8'h3C;
    img[10] = 8'h3C;
    tick();
    wr_en = 1'b0;

    // Frame D: reset at pixel 400.
    start_frame(4'h0, 1'b0);
    stream(400, -1, 4'h0, -1, 4'h0, -1);
    check("pixel_400", core_data, exp_pix_q.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_core_rst_n", core_rst_n, 0);
    check("mid_rst_core_data", core_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    exp_pix_q.delete();
    void'(exp_res_q.pop_front());
    tick();

    // Frame E: full replay from pixel 0 (pixel 5 still 5); start held through
    // WAIT/FIN to exercise the back-to-back path.
    start_frame(4'hC, 1'b0);
    stream(IMG_PIXELS, -1, 4'h0, -1, 4'h0, -1);
    await_done(20, 4'hC, 21, 1'b1);

    // Frame F: accepted in the single IDLE cycle after FIN.
    start_frame(4'h1, 1'b0);
    stream(IMG_PIXELS, -1, 4'h0, -1, 4'h0, -1);
    await_done(0, 4'h1, 1, 1'b0);
    tick();
    check("final_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
